seq_divider16x8: RTL and testbench

Sequential restoring divider: the inverse datapath of the 8x8 shift-add multiplier. It divides a 16-bit unsigned dividend by an 8-bit unsigned divisor, one quotient bit per clock. It returns a 16-bit quotient and an 8-bit remainder. It sits beside `multiplier8x8` in the arithmetic lab datapath, and a `product` from the multiplier can be fed straight back as a dividend.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 23 ++
 rtl/seq_divider16x8.sv | 119 +++++++++++
 tb/tb_seq_divider16x8.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int unsigned DIV_DW = 16;
  localparam int unsigned DIV_VW = 8;
  localparam int unsigned DIV_CW = $clog2(DIV_DW + 1);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned VW = 8
) (
  input  logic [VW-1:0] r,
  input  logic          q_msb,
  input  logic [VW-1:0] d,
  output logic [VW-1:0] r_next,
  output logic          q_bit
);

  logic [VW:0] r_shift;
  logic [VW:0] d_ext;

  // R' = 2R + bit with R < D keeps R' - D below 2^VW, so VW result bits are exact.
  always_comb begin
    r_shift = {r, q_msb};
    d_ext   = {1'b0, d};
    q_bit   = (r_shift >= d_ext);
    r_next  = q_bit ? VW'(r_shift - d_ext) : r_shift[VW-1:0];
  end

endmodule

// File: rtl/seq_divider16x8.sv
// 16/8 sequential restoring divider, one quotient bit per clock.
// Optional zero-divisor fast path: define SEQ_DIVIDER_DZ_CHECK_EN.
module seq_divider16x8
  import div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW
) (
  input  logic          clk,
  input  logic          areset_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          dz
);

  localparam int unsigned CW = $clog2(DW + 1);

  div_state_t    state, state_next;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] r_reg;
  logic [VW-1:0] d_reg;
  logic [CW-1:0] cnt;
  logic [VW-1:0] r_next;
  logic          q_bit;
  logic [DW-1:0] q_next;
  logic          accept;
  logic          last;

  // The top bit of the partial remainder is always zero between iterations; div_step keeps it internally.
  div_step #(.VW(VW)) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[DW-1]),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign q_next = {q_reg[DW-2:0], q_bit};
  assign last   = (cnt == CW'(DW - 1));
  assign busy   = (state == BUSY);
  assign done   = (state == DONE);

`ifdef SEQ_DIVIDER_DZ_CHECK_EN
  logic dz_pend;

  assign accept = start && (state != BUSY) && !dz_pend;

  // Zero divisor waits one idle cycle in dz_pend, then reports through DONE.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      dz      <= 1'b0;
      dz_pend <= 1'b0;
    end else if (accept) begin
      dz      <= 1'b0;
      dz_pend <= (divisor == '0);
    end else if (dz_pend) begin
      dz      <= 1'b1;
      dz_pend <= 1'b0;
    end
  end
`else
  assign accept = start && (state != BUSY);
  assign dz     = 1'b0;
`endif

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = accept ? BUSY : IDLE;
      BUSY:       if (last) state_next = DONE;
      default:    state_next = IDLE;
    endcase
`ifdef SEQ_DIVIDER_DZ_CHECK_EN
    if (accept && divisor == '0) state_next = IDLE;
    if (dz_pend)                 state_next = DONE;
`endif
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      q_reg     <= '0;
      r_reg     <= '0;
      d_reg     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      q_reg <= dividend;
      d_reg <= divisor;
      r_reg <= '0;
      cnt   <= '0;
    end else if (state == BUSY) begin
      q_reg <= q_next;
      r_reg <= r_next;
      cnt   <= cnt + CW'(1);
      if (last) begin
        quotient  <= q_next;
        remainder <= r_next;
      end
    end
`ifdef SEQ_DIVIDER_DZ_CHECK_EN
    else if (dz_pend) begin
      quotient  <= '1;
      remainder <= q_reg[VW-1:0];
    end
`endif
  end

endmodule

// File: tb/tb_seq_divider16x8.sv
// Directed, table-driven bench for seq_divider16x8 plus hand-written multi-cycle corner sequences.
module tb_seq_divider16x8;

`ifdef SEQ_DIVIDER_DZ_CHECK_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        dz;

  int checks = 0;
  int errors = 0;

  seq_divider16x8 dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [15:0] q;
    logic [7:0]  r;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one cycle, then sample each falling edge until done (bounded).
  // lat = edges after the accepting edge at which done is first seen, -1 on timeout.
  task automatic do_op(input logic [15:0] dd, input logic [7:0] dv,
                       output int lat, output int busy_cnt, output int overlap);
    lat = -1;
    busy_cnt = 0;
    overlap = 0;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy && done) overlap = 1;
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  vec_t vecs[$];
  int   lat, bcnt, ovl, exp_lat, exp_busy;

  initial begin
    vecs.push_back('{16'd5500,  8'd100, 16'd55,    8'd0});
    vecs.push_back('{16'd65025, 8'd255, 16'd255,   8'd0});
    vecs.push_back('{16'd1000,  8'd7,   16'd142,   8'd6});
    vecs.push_back('{16'd65535, 8'd1,   16'd65535, 8'd0});
    vecs.push_back('{16'd1,     8'd0,   16'hFFFF,  8'd1});
    vecs.push_back('{16'd300,   8'd9,   16'd33,    8'd3});
    vecs.push_back('{16'd10,    8'd2,   16'd5,     8'd0});
    vecs.push_back('{16'd0,     8'd5,   16'd0,     8'd0});
    vecs.push_back('{16'd255,   8'd16,  16'd15,    8'd15});
    vecs.push_back('{16'd65535, 8'd255, 16'd257,   8'd0});
    vecs.push_back('{16'd12345, 8'd123, 16'd100,   8'd45});

    // Reset state
    #12;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", dz, 0);
    @(negedge clk);
    areset_n = 1'b1;

    foreach (vecs[k]) begin
      do_op(vecs[k].dd, vecs[k].dv, lat, bcnt, ovl);
      exp_lat  = (DZ_EN && vecs[k].dv == 0) ? 1 : 16;
      exp_busy = (DZ_EN && vecs[k].dv == 0) ? 0 : 16;
      check($sformatf("v%0d_latency", k), lat, exp_lat);
      check($sformatf("v%0d_busy_cycles", k), bcnt, exp_busy);
      check($sformatf("v%0d_busy_done_overlap", k), ovl, 0);
      check($sformatf("v%0d_quotient", k), quotient, vecs[k].q);
      check($sformatf("v%0d_remainder", k), remainder, vecs[k].r);
      check($sformatf("v%0d_dz", k), dz, (DZ_EN && vecs[k].dv == 0) ? 1 : 0);
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", k), done, 0);
    end

    // Back-to-back: restart in the DONE cycle, no bubble, old result held
    do_op(16'd1000, 8'd7, lat, bcnt, ovl);
    check("b2b_first_quotient", quotient, 142);
    check("b2b_first_remainder", remainder, 6);
    dividend = 16'd65535;
    divisor  = 8'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_no_bubble", busy, 1);
    check("b2b_quotient_held", quotient, 142);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check("b2b_latency", lat, 16);
    check("b2b_quotient", quotient, 65535);
    check("b2b_remainder", remainder, 0);

    // start while BUSY is ignored
    @(negedge clk);
    dividend = 16'd300;
    divisor  = 8'd9;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 16'd10;
    divisor  = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 5; i < 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check("ignore_latency", lat, 16);
    check("ignore_quotient", quotient, 33);
    check("ignore_remainder", remainder, 3);

    // Asynchronous reset mid-operation
    @(negedge clk);
    dividend = 16'd5500;
    divisor  = 8'd100;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    areset_n = 1'b0;
    #1;
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_dz", dz, 0);
    ovl = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) ovl = 1;
    end
    areset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) ovl = 1;
    end
    check("mid_rst_no_activity", ovl, 0);
    do_op(16'd1, 8'd1, lat, bcnt, ovl);
    check("post_rst_latency", lat, 16);
    check("post_rst_quotient", quotient, 1);
    check("post_rst_remainder", remainder, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
